matrix_scan: RTL and testbench
==============================

# matrix_scan

Row-scan sequencer and double-buffered frame store for the 8x8 LED matrix. It sits directly upstream of the column driver. It holds the displayed pong frame and walks the active row at a fixed prescaled rate. For the current row it presents the row index plus the even/odd row pair the column driver selects from. New frames from game logic enter through a valid/ready handshake and are swapped in only at a frame boundary, so the display never tears.

## Interface
- ROW, 8, matrix rows
- COL, 8, matrix columns
- BIT_COUNT, 3, log2(ROW); width of count_row
- PRESCALE, 1024, clk cycles per row dwell (>= BLANK+2)
- PS_W, 10, prescaler width, >= clog2(PRESCALE)
- BLANK, 4, cycles at the start of each row dwell with all rows off
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_in  in  ROW*COL  new frame; row r at bits [r*COL +: COL]; bit=1 means LED on
- frame_valid  in  1  frame_in valid
- frame_ready  out  1  pending buffer empty; frame accepted on valid&ready
- count_row  out  BIT_COUNT  current row index, to column driver
- input_matrix  out  2*COL  {row[count_row|1], row[count_row&~1]} of the active buffer
- row_sel_n  out  ROW  active-low one-hot row enable
- frame_start  out  1  one-cycle pulse when count_row wraps to 0

## Operation
- Prescaler ps counts 0..PRESCALE-1 and wraps. Terminal count tc = (ps==PRESCALE-1).
- On tc, count_row increments and wraps from ROW-1 to 0.
- input_matrix is registered and loaded on the same edge as count_row. It is computed from the next row index and the buffer that is active after that edge, so the pair always matches count_row.
- row_sel_n is registered:
  - all ones while ps < BLANK;
  - otherwise bit count_row is low and the rest high.
  - Blanking covers the one-cycle register lag in the column driver.
- Pending-buffer FSM has two states:
  - EMPTY: frame_ready=1. On frame_valid, capture frame_in into pending and go to FULL.
  - FULL: frame_ready=0; frame_valid is ignored. On frame boundary (tc && count_row==ROW-1), copy pending to active and go to EMPTY.
- Simultaneous capture and boundary in EMPTY: the frame goes to pending, not active. It is displayed at the next boundary.
- In FULL, the swap and the row-0 input_matrix load happen on the same edge. Row 0/1 of the new frame are shown immediately.
- frame_start is asserted for the single cycle after count_row becomes 0, coincident with the new count_row value.
- Reset values (asynchronous):
  - ps=0, count_row=0;
  - active=0, pending=0, FSM EMPTY (frame_ready=1);
  - input_matrix=0, row_sel_n all ones, frame_start=0.
- Reset asserted mid-frame discards both buffers. Scanning restarts at row 0 with a blank frame.

## Timing
- Row dwell is exactly PRESCALE cycles. A full frame is ROW*PRESCALE cycles.
- First count_row change occurs PRESCALE cycles after rst_n deasserts.
- Handshake latency: frame accepted on the valid&ready edge. frame_ready drops the following cycle. Frame becomes visible at the next frame boundary, at most ROW*PRESCALE cycles later.
- row_sel_n goes active BLANK cycles after each count_row change and releases on the next change.
- No combinational path from frame_valid to any output other than via registers. frame_ready is a direct decode of FSM state.

## Structure
- Shared package matrix_pkg:
  - ROW, COL, BIT_COUNT constants;
  - pend_state_t enum {EMPTY, FULL};
  - function row_of(frame, idx) returning COL bits.
  - The column driver imports the same constants.
- One sub-module, scan_prescaler: ps counter, tc, and the blank flag (ps<BLANK).
- Buffers, FSM, and output registers live in matrix_scan.

## Test plan
- Reset then idle, PRESCALE=8, BLANK=2 -> count_row steps 0..7 every 8 cycles. frame_start pulses every 64 cycles. input_matrix=0. row_sel_n=8'hFF for ps<2, else ~(1<<count_row).
- Load frame with row r = 8'h01<<r mid-frame -> frame_ready low the next cycle. At count_row 0 after the boundary, input_matrix=16'h0201; at row 2, input_matrix=16'h0804. frame_ready returns high on the swap.
- Second frame_valid while FULL -> ignored. Displayed frame is the first one; a third frame offered after the swap is accepted.
- frame_valid asserted exactly on the boundary edge while EMPTY -> the frame goes to pending. The active frame is unchanged for the next 64 cycles, then the new frame appears.
- rst_n pulsed low at row 5 with a frame displayed -> outputs return immediately to reset values. After release, scanning restarts at row 0 with input_matrix=0.
- PRESCALE=1024 default run for 2 frames -> 8192 cycles between second-frame start and third-frame start; no row_sel_n glitch (at most one low bit, ever).

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg
// Constants and types shared by the LED-matrix row scanner and the column
// driver.
//   ROW, COL      : matrix geometry
//   BIT_COUNT     : width of a row index
//   pend_state_t  : state of the pending frame buffer
//   row_of()      : extracts one row (COL bits) from a packed frame
package matrix_pkg;

    localparam int ROW       = 8;
    localparam int COL       = 8;
    localparam int BIT_COUNT = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } pend_state_t;

    // Row r of a frame lives at bits [r*COL +: COL].
    function automatic logic [COL-1:0] row_of(input logic [ROW*COL-1:0]  frame,
                                              input logic [BIT_COUNT-1:0] idx);
        return frame[idx*COL +: COL];
    endfunction

endpackage

// File: rtl/matrix_scan_prescaler.sv
// scan_prescaler
// Free-running row-dwell prescaler for the matrix scanner.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tc         out  terminal count, high while ps == PRESCALE-1
//   blank_nxt  out  blank flag (ps < BLANK) for the cycle after this edge
module scan_prescaler #(
    parameter int PRESCALE = 1024,
    parameter int PS_W     = 10,
    parameter int BLANK    = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tc,
    output logic blank_nxt
);

    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] ps_nxt;

    assign tc     = (ps == PS_W'(PRESCALE - 1));
    assign ps_nxt = tc ? '0 : ps + 1'b1;

    // Look one cycle ahead so the registered row enables honour the blank
    // window exactly, with no extra cycle of lag.
    assign blank_nxt = (ps_nxt < PS_W'(BLANK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps <= '0;
        end else begin
            ps <= ps_nxt;
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan
// Row-scan sequencer and double-buffered frame store for the 8x8 LED matrix.
// New frames are captured into a pending buffer through a valid/ready
// handshake and copied to the active buffer only at a frame boundary, so the
// display never tears.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   frame_in      in   new frame, row r at [r*COL +: COL], 1 = LED on
//   frame_valid   in   frame_in valid
//   frame_ready   out  pending buffer empty; accept on valid & ready
//   count_row     out  current row index
//   input_matrix  out  {row[count_row|1], row[count_row&~1]} of active frame
//   row_sel_n     out  active-low one-hot row enable (all high while blanking)
//   frame_start   out  one-cycle pulse while count_row is newly 0
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int PRESCALE = 1024,
    parameter int PS_W     = 10,
    parameter int BLANK    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROW*COL-1:0]   frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [BIT_COUNT-1:0] count_row,
    output logic [2*COL-1:0]     input_matrix,
    output logic [ROW-1:0]       row_sel_n,
    output logic                 frame_start
);

    logic                 tc;
    logic                 blank_nxt;
    logic                 boundary;
    logic                 capture;
    logic                 swap;
    pend_state_t          state;
    pend_state_t          state_nxt;
    logic [ROW*COL-1:0]   active;
    logic [ROW*COL-1:0]   pending;
    logic [ROW*COL-1:0]   active_nxt;
    logic [BIT_COUNT-1:0] row_nxt;
    logic [BIT_COUNT-1:0] even_idx;
    logic [BIT_COUNT-1:0] odd_idx;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W),
        .BLANK    (BLANK)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .tc        (tc),
        .blank_nxt (blank_nxt)
    );

    assign boundary = tc && (count_row == BIT_COUNT'(ROW - 1));

    assign row_nxt = !tc                                  ? count_row :
                     (count_row == BIT_COUNT'(ROW - 1))   ? '0        :
                                                            count_row + 1'b1;

    // Pending-buffer FSM. A capture in EMPTY always lands in pending, even
    // on the boundary edge; it becomes visible one frame later.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        swap      = 1'b0;
        case (state)
            EMPTY: begin
                if (frame_valid) begin
                    capture   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (boundary) begin
                    swap      = 1'b1;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign frame_ready = (state == EMPTY);

    // The row pair is taken from the buffer that is active after this edge,
    // so rows 0/1 of a freshly swapped frame appear together with row 0.
    assign active_nxt = swap ? pending : active;
    assign even_idx   = row_nxt & ~BIT_COUNT'(1);
    assign odd_idx    = row_nxt |  BIT_COUNT'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            active       <= '0;
            pending      <= '0;
            count_row    <= '0;
            input_matrix <= '0;
            row_sel_n    <= '1;
            frame_start  <= 1'b0;
        end else begin
            state     <= state_nxt;
            active    <= active_nxt;
            count_row <= row_nxt;
            if (capture) begin
                pending <= frame_in;
            end
            if (tc) begin
                input_matrix <= {row_of(active_nxt, odd_idx), row_of(active_nxt, even_idx)};
            end
            // Blank window hides the column driver's one-cycle register lag.
            row_sel_n   <= blank_nxt ? '1 : ~(ROW'(1) << row_nxt);
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
module tb_matrix_scan;
    import matrix_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ROW*COL-1:0]   frame_in;
    logic                 frame_valid;

    logic                 frame_ready;
    logic [BIT_COUNT-1:0] count_row;
    logic [2*COL-1:0]     input_matrix;
    logic [ROW-1:0]       row_sel_n;
    logic                 frame_start;

    logic                 frame_ready_b;
    logic [BIT_COUNT-1:0] count_row_b;
    logic [2*COL-1:0]     input_matrix_b;
    logic [ROW-1:0]       row_sel_n_b;
    logic                 frame_start_b;

    int checks   = 0;
    int failures = 0;
    int glitches = 0;

    always #5 clk = ~clk;

    matrix_scan #(.PRESCALE(8), .PS_W(4), .BLANK(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_in     (frame_in),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .count_row    (count_row),
        .input_matrix (input_matrix),
        .row_sel_n    (row_sel_n),
        .frame_start  (frame_start)
    );

    matrix_scan #(.PRESCALE(1024), .PS_W(10), .BLANK(4)) dut_big (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_in     ('0),
        .frame_valid  (1'b0),
        .frame_ready  (frame_ready_b),
        .count_row    (count_row_b),
        .input_matrix (input_matrix_b),
        .row_sel_n    (row_sel_n_b),
        .frame_start  (frame_start_b)
    );

    // At most one row may ever be enabled.
    always @(negedge clk) begin
        if ($countones(~row_sel_n) > 1)   glitches++;
        if ($countones(~row_sel_n_b) > 1) glitches++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_fs(input int maxc, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_start && n < maxc);
        check("fs_seen", 32'(frame_start), 32'd1);
    endtask

    typedef struct {
        int             k;
        logic [2:0]     cr;
        logic [7:0]     rs;
        logic           fs;
        logic [15:0]    im;
        logic           fr;
    } vec_t;

    vec_t tbl[10];
    logic [ROW*COL-1:0] fa, fb, fc, fd;
    int cur, n, cyc, first_chg, nfs;
    int fs_cyc[4];

    initial begin
        tbl[0] = '{0,  3'd0, 8'hFF, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{1,  3'd0, 8'hFF, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{2,  3'd0, 8'hFE, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{7,  3'd0, 8'hFE, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{8,  3'd1, 8'hFF, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{10, 3'd1, 8'hFD, 1'b0, 16'h0000, 1'b1};
        tbl[6] = '{63, 3'd7, 8'h7F, 1'b0, 16'h0000, 1'b1};
        tbl[7] = '{64, 3'd0, 8'hFF, 1'b1, 16'h0000, 1'b1};
        tbl[8] = '{65, 3'd0, 8'hFF, 1'b0, 16'h0000, 1'b1};
        tbl[9] = '{66, 3'd0, 8'hFE, 1'b0, 16'h0000, 1'b1};

        for (int r = 0; r < ROW; r++) begin
            fa[r*COL +: COL] = 8'h01 << r;
            fb[r*COL +: COL] = 8'h80 >> r;
            fc[r*COL +: COL] = 8'(8'h10 + r);
            fd[r*COL +: COL] = 8'(8'hA0 + r);
        end

        frame_in    = '0;
        frame_valid = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle scan after reset, sampled at hand-picked cycle counts.
        cur = 0;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].k - cur);
            cur = tbl[i].k;
            check($sformatf("idle_cr_k%0d", tbl[i].k), 32'(count_row),    32'(tbl[i].cr));
            check($sformatf("idle_rs_k%0d", tbl[i].k), 32'(row_sel_n),    32'(tbl[i].rs));
            check($sformatf("idle_fs_k%0d", tbl[i].k), 32'(frame_start),  32'(tbl[i].fs));
            check($sformatf("idle_im_k%0d", tbl[i].k), 32'(input_matrix), 32'(tbl[i].im));
            check($sformatf("idle_fr_k%0d", tbl[i].k), 32'(frame_ready),  32'(tbl[i].fr));
        end

        // Frame A mid-frame, then a second offer while FULL must be ignored.
        frame_in = fa; frame_valid = 1'b1;
        step(1);                                  // k=67
        frame_valid = 1'b0;
        check("ready_drop", 32'(frame_ready), 32'd0);
        frame_in = fb; frame_valid = 1'b1;
        step(3);                                  // k=70
        check("ready_full_ignore", 32'(frame_ready), 32'd0);
        frame_valid = 1'b0;
        step(57);                                 // k=127, row 7
        check("pre_swap_cr", 32'(count_row), 32'd7);
        check("pre_swap_im", 32'(input_matrix), 32'h0000);
        wait_fs(70, n);                           // k=128
        check("swap_latency", 32'(n), 32'd1);
        check("swapA_cr", 32'(count_row), 32'd0);
        check("swapA_im_r0", 32'(input_matrix), 32'h0201);
        check("swapA_ready", 32'(frame_ready), 32'd1);
        step(16);                                 // k=144, row 2
        check("swapA_cr2", 32'(count_row), 32'd2);
        check("swapA_im_r2", 32'(input_matrix), 32'h0804);

        // Third frame offered after the swap is accepted.
        frame_in = fc; frame_valid = 1'b1;
        step(1);                                  // k=145
        frame_valid = 1'b0;
        check("fc_ready_drop", 32'(frame_ready), 32'd0);
        wait_fs(70, n);                           // k=192
        check("fc_wait", 32'(n), 32'd47);
        check("swapC_im_r0", 32'(input_matrix), 32'h1110);
        check("swapC_ready", 32'(frame_ready), 32'd1);

        // Frame offered exactly on the boundary edge while EMPTY.
        step(63);                                 // k=255, row 7, ps 7
        check("bnd_pre_cr", 32'(count_row), 32'd7);
        check("bnd_pre_ready", 32'(frame_ready), 32'd1);
        frame_in = fd; frame_valid = 1'b1;
        step(1);                                  // k=256, boundary edge taken
        frame_valid = 1'b0;
        check("bnd_fs", 32'(frame_start), 32'd1);
        check("bnd_im_keepC", 32'(input_matrix), 32'h1110);
        check("bnd_ready", 32'(frame_ready), 32'd0);
        step(16);                                 // k=272, row 2
        check("bnd_im_r2_keepC", 32'(input_matrix), 32'h1312);
        wait_fs(70, n);                           // k=320
        check("bnd_wait", 32'(n), 32'd48);
        check("swapD_im_r0", 32'(input_matrix), 32'hA1A0);
        check("swapD_ready", 32'(frame_ready), 32'd1);

        // Asynchronous reset at row 5 with frame D displayed.
        step(43);                                 // k=363, row 5, ps 3
        check("rst_pre_cr", 32'(count_row), 32'd5);
        check("rst_pre_im", 32'(input_matrix), 32'hA5A4);
        check("rst_pre_rs", 32'(row_sel_n), 32'hDF);
        rst_n = 1'b0;
        #1;
        check("rst_cr", 32'(count_row), 32'd0);
        check("rst_im", 32'(input_matrix), 32'h0000);
        check("rst_rs", 32'(row_sel_n), 32'hFF);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_fr", 32'(frame_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(8);
        check("post_rst_cr", 32'(count_row), 32'd1);
        check("post_rst_im", 32'(input_matrix), 32'h0000);
        wait_fs(70, n);
        check("post_rst_fs_wait", 32'(n), 32'd56);
        check("post_rst_im_r0", 32'(input_matrix), 32'h0000);

        // Default-prescale instance: row and frame timing.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; first_chg = 0; nfs = 0;
        for (int i = 0; i < 4; i++) fs_cyc[i] = 0;
        while (nfs < 3 && cyc < 30000) begin
            step(1);
            cyc++;
            if (first_chg == 0 && count_row_b != 0) first_chg = cyc;
            if (frame_start_b) begin
                nfs++;
                fs_cyc[nfs] = cyc;
            end
        end
        check("big_nfs", 32'(nfs), 32'd3);
        check("big_first_row", 32'(first_chg), 32'd1024);
        check("big_first_fs", 32'(fs_cyc[1]), 32'd8192);
        check("big_frame_len", 32'(fs_cyc[3] - fs_cyc[2]), 32'd8192);
        check("big_im", 32'(input_matrix_b), 32'h0000);
        check("big_ready", 32'(frame_ready_b), 32'd1);
        check("no_rowsel_glitch", 32'(glitches), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
